// File: rtl/mem_arb_pkg.sv
// Shared types for the instr/data MEM arbiter: FSM states and transaction owner IDs.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_t;

  function automatic owner_t flip_owner(input owner_t o);
    return (o == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
  endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of owner IDs for granted-but-unanswered transactions.
module mem_arb_id_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  owner_t push_id_i,
  input  logic   pop_i,
  output logic   full_o,
  output logic   empty_o,
  output owner_t head_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  owner_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW:0]     count_q;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  // A pop on an empty FIFO is a spurious response and leaves the state alone.
  assign do_pop  = pop_i & ~empty_o;

  // Storage, pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_id_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_instr_data_arbiter.sv
// Round-robin arbiter sharing one MEM master port between instr and data ports.
// Optional feature: define MEM_ARB_PERF_EN for per-owner saturating grant counters.
module mem_instr_data_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    instr_mem_req,
  output logic                    instr_mem_gnt,
  output logic                    instr_mem_valid,
  input  logic [ADDR_WIDTH-1:0]   instr_mem_addr,
  output logic [DATA_WIDTH-1:0]   instr_mem_rdata,
  input  logic                    data_mem_req,
  input  logic                    data_mem_we,
  output logic                    data_mem_gnt,
  output logic                    data_mem_valid,
  input  logic [ADDR_WIDTH-1:0]   data_mem_addr,
  input  logic [DATA_WIDTH/8-1:0] data_mem_be,
  input  logic [DATA_WIDTH-1:0]   data_mem_wdata,
  output logic [DATA_WIDTH-1:0]   data_mem_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  input  logic                    mem_gnt,
  input  logic                    mem_valid,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]             instr_grant_cnt_o,
  output logic [31:0]             data_grant_cnt_o,
`endif
  output logic                    err_o
);

  arb_state_t state_q;
  owner_t     rr_q;
  owner_t     sel;
  owner_t     head_id;
  logic       req_ok;
  logic       fifo_full;
  logic       fifo_empty;
  logic       handshake;
  logic       resp_ok;

  // Owner selection: round-robin in IDLE, pinned to the locked owner otherwise
  always_comb begin
    sel    = OWNER_INSTR;
    req_ok = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_mem_req && data_mem_req) begin
          sel    = rr_q;
          req_ok = 1'b1;
        end else if (data_mem_req) begin
          sel    = OWNER_DATA;
          req_ok = 1'b1;
        end else if (instr_mem_req) begin
          sel    = OWNER_INSTR;
          req_ok = 1'b1;
        end else begin
          sel    = rr_q;
          req_ok = 1'b0;
        end
      end
      LOCK_I: begin
        sel    = OWNER_INSTR;
        req_ok = instr_mem_req;
      end
      LOCK_D: begin
        sel    = OWNER_DATA;
        req_ok = data_mem_req;
      end
      default: begin
        sel    = OWNER_INSTR;
        req_ok = 1'b0;
      end
    endcase
  end

  // Full gating deliberately ignores a same-cycle pop to keep the path short.
  assign mem_req   = req_ok & ~fifo_full & ~rst_i;
  assign handshake = mem_req & mem_gnt;

  // Shared-port payload mux
  always_comb begin
    if (sel == OWNER_DATA) begin
      mem_addr  = data_mem_addr;
      mem_we    = data_mem_we;
      mem_be    = data_mem_be;
      mem_wdata = data_mem_wdata;
    end else begin
      mem_addr  = instr_mem_addr;
      mem_we    = 1'b0;
      mem_be    = '1;
      mem_wdata = '0;
    end
  end

  assign instr_mem_gnt   = handshake & (sel == OWNER_INSTR);
  assign data_mem_gnt    = handshake & (sel == OWNER_DATA);
  assign resp_ok         = mem_valid & ~fifo_empty & ~rst_i;
  assign instr_mem_valid = resp_ok & (head_id == OWNER_INSTR);
  assign data_mem_valid  = resp_ok & (head_id == OWNER_DATA);
  assign instr_mem_rdata = mem_rdata;
  assign data_mem_rdata  = mem_rdata;

  mem_arb_id_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (handshake),
    .push_id_i(sel),
    .pop_i    (mem_valid),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .head_o   (head_id)
  );

  // Arbitration FSM, round-robin pointer and sticky spurious-response flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= OWNER_INSTR;
      err_o   <= 1'b0;
    end else begin
      if (mem_valid && fifo_empty) begin
        err_o <= 1'b1;
      end
      if (handshake) begin
        rr_q <= flip_owner(rr_q);
      end
      case (state_q)
        IDLE: begin
          if (mem_req && !mem_gnt) begin
            state_q <= (sel == OWNER_DATA) ? LOCK_D : LOCK_I;
          end
        end
        LOCK_I, LOCK_D: begin
          // A dropped request while locked is abandoned without a push.
          if (handshake || !req_ok) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  // Saturating per-owner handshake counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_grant_cnt_o <= 32'd0;
      data_grant_cnt_o  <= 32'd0;
    end else begin
      if (instr_mem_gnt && (instr_grant_cnt_o != 32'hFFFF_FFFF)) begin
        instr_grant_cnt_o <= instr_grant_cnt_o + 32'd1;
      end
      if (data_mem_gnt && (data_grant_cnt_o != 32'hFFFF_FFFF)) begin
        data_grant_cnt_o <= data_grant_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_instr_data_arbiter.sv
// Scoreboard bench for mem_instr_data_arbiter; expected response owners are queued at grant time.
module tb_mem_instr_data_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq, igt, ivalid;
  logic [31:0] iaddr, irdata;
  logic        dreq, dwe, dgt, dvalid;
  logic [31:0] daddr, dwdata, drdata;
  logic [3:0]  dbe;
  logic        mreq, mwe, mgnt, mvalid;
  logic [31:0] maddr, mwdata, mrdata;
  logic [3:0]  mbe;
  logic        err;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] icnt, dcnt;
`endif

  int   n_vec = 0;
  int   n_mis = 0;
  logic exp_q[$];
  logic rr_exp;
  int   exp_icnt, exp_dcnt;

  always #5 clk = ~clk;

  mem_instr_data_arbiter dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .instr_mem_req  (ireq),
    .instr_mem_gnt  (igt),
    .instr_mem_valid(ivalid),
    .instr_mem_addr (iaddr),
    .instr_mem_rdata(irdata),
    .data_mem_req   (dreq),
    .data_mem_we    (dwe),
    .data_mem_gnt   (dgt),
    .data_mem_valid (dvalid),
    .data_mem_addr  (daddr),
    .data_mem_be    (dbe),
    .data_mem_wdata (dwdata),
    .data_mem_rdata (drdata),
    .mem_req        (mreq),
    .mem_we         (mwe),
    .mem_gnt        (mgnt),
    .mem_valid      (mvalid),
    .mem_addr       (maddr),
    .mem_be         (mbe),
    .mem_wdata      (mwdata),
    .mem_rdata      (mrdata),
`ifdef MEM_ARB_PERF_EN
    .instr_grant_cnt_o(icnt),
    .data_grant_cnt_o (dcnt),
`endif
    .err_o          (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ireq = 1'b0; iaddr = 32'd0;
    dreq = 1'b0; dwe = 1'b0; daddr = 32'd0; dbe = 4'h0; dwdata = 32'd0;
    mgnt = 1'b0; mvalid = 1'b0; mrdata = 32'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    rr_exp   = 1'b0;
    exp_icnt = 0;
    exp_dcnt = 0;
  endtask

  // One cycle with mem_gnt=1 where the bench expects exp_owner to win at exp_addr.
  task automatic grant_cycle(input logic exp_owner, input logic [31:0] exp_addr);
    mgnt = 1'b1;
    #2;
    check("mem_req", mreq, 1'b1);
    check("instr_gnt", igt, exp_owner == 1'b0);
    check("data_gnt", dgt, exp_owner == 1'b1);
    check("mem_addr", maddr, exp_addr);
    exp_q.push_back(exp_owner);
    if (exp_owner) exp_dcnt++;
    else exp_icnt++;
    rr_exp = ~rr_exp;
    step();
  endtask

  task automatic check_resp(input logic [31:0] rd);
    logic o;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      o = exp_q.pop_front();
      check("instr_valid", ivalid, o == 1'b0);
      check("data_valid", dvalid, o == 1'b1);
      check(o ? "data_rdata" : "instr_rdata", o ? drdata : irdata, rd);
    end
  endtask

  task automatic respond(input logic [31:0] rd);
    mgnt = 1'b0; mvalid = 1'b1; mrdata = rd;
    #2;
    check_resp(rd);
    step();
    mvalid = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_exp_init: begin
      rr_exp = 1'b0; exp_icnt = 0; exp_dcnt = 0;
    end
    // Reset with every request asserted: outputs must stay quiet.
    rst = 1'b1; ireq = 1'b1; dreq = 1'b1; mgnt = 1'b1; mvalid = 1'b1;
    step();
    #2;
    check("rst_mem_req", mreq, 1'b0);
    check("rst_igt", igt, 1'b0);
    check("rst_dgt", dgt, 1'b0);
    check("rst_ivalid", ivalid, 1'b0);
    check("rst_dvalid", dvalid, 1'b0);
    check("rst_err", err, 1'b0);
    do_reset();

    // 1: single instr read
    ireq = 1'b1; iaddr = 32'h100;
    mgnt = 1'b1;
    #2;
    check("t1_we", mwe, 1'b0);
    check("t1_be", mbe, 4'hF);
    #1;
    grant_cycle(1'b0, 32'h100);
    ireq = 1'b0;
    respond(32'hDEAD_BEEF);

    // 2: both held with continuous grant -> I,D,I,D
    do_reset();
    ireq = 1'b1; dreq = 1'b1;
    for (int k = 0; k < 4; k++) begin
      iaddr = 32'h1000 + 32'(k);
      daddr = 32'h2000 + 32'(k);
      grant_cycle(rr_exp, rr_exp ? daddr : iaddr);
    end
    ireq = 1'b0; dreq = 1'b0;
    for (int k = 0; k < 4; k++) respond(32'hA000_0000 + 32'(k));

    // 3: data locked for three stalled cycles while instr joins
    do_reset();
    dreq = 1'b1; daddr = 32'h200; iaddr = 32'h300;
    for (int k = 1; k <= 3; k++) begin
      if (k >= 2) ireq = 1'b1;
      mgnt = 1'b0;
      #2;
      check("t3_hold_addr", maddr, 32'h200);
      check("t3_hold_igt", igt, 1'b0);
      step();
    end
    grant_cycle(1'b1, 32'h200);
    dreq = 1'b0;
    grant_cycle(1'b0, 32'h300);
    ireq = 1'b0;
    respond(32'h1111_2222);
    respond(32'h3333_4444);

    // 4: outstanding limit gating
    do_reset();
    ireq = 1'b1;
    for (int k = 0; k < 4; k++) begin
      iaddr = 32'h400 + 32'(4 * k);
      grant_cycle(1'b0, iaddr);
    end
    mgnt = 1'b1;
    #2;
    check("t4_full_req", mreq, 1'b0);
    check("t4_full_igt", igt, 1'b0);
    step();
    mvalid = 1'b1; mrdata = 32'h5555_0000;
    #2;
    check("t4_pop_req", mreq, 1'b0);
    check_resp(32'h5555_0000);
    step();
    mvalid = 1'b0;
    iaddr  = 32'h500;
    grant_cycle(1'b0, 32'h500);
    ireq = 1'b0; mgnt = 1'b0;
    for (int k = 0; k < 4; k++) respond(32'h6000_0000 + 32'(k));

    // 5: spurious response with empty FIFO
    mvalid = 1'b1; mrdata = 32'h7777_7777;
    #2;
    check("t5_ivalid", ivalid, 1'b0);
    check("t5_dvalid", dvalid, 1'b0);
    check("t5_err_same", err, 1'b0);
    step();
    mvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      check("t5_err_sticky", err, 1'b1);
      step();
    end
    do_reset();
    #2;
    check("t5_err_clr", err, 1'b0);
    step();

    // 6: reset with two outstanding data writes, then a late response
    dreq = 1'b1; dwe = 1'b1; dbe = 4'h3;
    for (int k = 0; k < 2; k++) begin
      daddr  = 32'h600 + 32'(4 * k);
      dwdata = 32'hCAFE_0000 + 32'(k);
      #2;
      check("t6_we", mwe, 1'b1);
      check("t6_be", mbe, 4'h3);
      check("t6_wdata", mwdata, dwdata);
      #1;
      grant_cycle(1'b1, daddr);
    end
    dreq = 1'b0; dwe = 1'b0; mgnt = 1'b0;
`ifdef MEM_ARB_PERF_EN
    #2;
    check("t6_dcnt", dcnt, 32'(exp_dcnt));
    check("t6_icnt", icnt, 32'(exp_icnt));
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    exp_icnt = 0; exp_dcnt = 0; rr_exp = 1'b0;
`ifdef MEM_ARB_PERF_EN
    #2;
    check("t6_dcnt_rst", dcnt, 32'(exp_dcnt));
    check("t6_icnt_rst", icnt, 32'(exp_icnt));
    #1;
    step();
`endif
    mvalid = 1'b1; mrdata = 32'h8888_8888;
    #2;
    check("t6_ivalid", ivalid, 1'b0);
    check("t6_dvalid", dvalid, 1'b0);
    step();
    mvalid = 1'b0;
    #2;
    check("t6_err", err, 1'b1);
    // Arbiter still serves a fresh request after the flush.
    #1;
    ireq = 1'b1; iaddr = 32'h700;
    grant_cycle(1'b0, 32'h700);
    ireq = 1'b0;
    respond(32'h9999_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
